multicycle_controller: RTL and testbench

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

---
 rtl/riscv_pkg.sv | 35 +++
 rtl/alu_decoder.sv | 31 +++
 rtl/multicycle_controller.sv | 152 +++++++++++++++
 tb/tb_multicycle_controller.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared encodings for the multicycle controller: opcodes, ALU operation codes
// and the controller state enumeration.
package riscv_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_op_t;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEM_ADR,
        MEM_READ,
        MEM_WB,
        MEM_WRITE,
        EXEC_R,
        EXEC_I,
        ALU_WB,
        BEQ,
        JAL,
        ERROR
    } state_t;

endpackage

// File: rtl/alu_decoder.sv
// Maps funct3/funct7 to an ALU operation for R-type and I-type arithmetic,
// flagging encodings the datapath does not implement.
module alu_decoder
    import riscv_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       is_rtype,
    output alu_op_t    alu_op,
    output logic       illegal
);

    always_comb begin
        alu_op  = ALU_ADD;
        illegal = 1'b0;
        // R-type only accepts funct7 = 0, plus 0100000 for SUB.
        if (is_rtype && !(funct7 == 7'b0000000 ||
                          (funct7 == 7'b0100000 && funct3 == 3'b000))) begin
            illegal = 1'b1;
        end else begin
            case (funct3)
                3'b000:  alu_op = (is_rtype && funct7[5]) ? ALU_SUB : ALU_ADD;
                3'b111:  alu_op = ALU_AND;
                3'b110:  alu_op = ALU_OR;
                3'b010:  alu_op = ALU_SLT;
                default: illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V style control FSM: sequences fetch, decode, memory, ALU and
// branch steps and drives datapath selects and write strobes from the state.
module multicycle_controller
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instruction,
    input  logic        zero_flag,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        adr_sel,
    output logic        ir_write,
    output logic        pc_write,
    output logic        reg_write,
    output logic [1:0]  alu_src_a_sel,
    output logic [1:0]  alu_src_b_sel,
    output logic [2:0]  alu_operation_sel,
    output logic [1:0]  imm_sel_out,
    output logic [1:0]  result_sel,
    output logic        illegal_instr,
    output logic        instr_retired
);

    state_t     state_reg;
    logic [6:0] opcode;
    alu_op_t    dec_op;
    logic       dec_illegal;
    logic       unused_instr_bits;

    assign opcode            = instruction[6:0];
    assign unused_instr_bits = ^{instruction[24:15], instruction[11:7]};

    alu_decoder u_alu_decoder (
        .funct3   (instruction[14:12]),
        .funct7   (instruction[31:25]),
        .is_rtype (opcode == OP_RTYPE),
        .alu_op   (dec_op),
        .illegal  (dec_illegal)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= FETCH;
        end else begin
            case (state_reg)
                FETCH:     if (mem_ready) state_reg <= DECODE;
                DECODE: begin
                    case (opcode)
                        OP_LOAD, OP_STORE: state_reg <= MEM_ADR;
                        OP_RTYPE:          state_reg <= EXEC_R;
                        OP_ITYPE:          state_reg <= EXEC_I;
                        OP_BRANCH:         state_reg <= BEQ;
                        OP_JAL:            state_reg <= JAL;
                        default:           state_reg <= ERROR;
                    endcase
                end
                MEM_ADR:   state_reg <= (opcode == OP_LOAD) ? MEM_READ : MEM_WRITE;
                MEM_READ:  if (mem_ready) state_reg <= MEM_WB;
                MEM_WB:    state_reg <= FETCH;
                MEM_WRITE: if (mem_ready) state_reg <= FETCH;
                EXEC_R,
                EXEC_I:    state_reg <= dec_illegal ? ERROR : ALU_WB;
                ALU_WB:    state_reg <= FETCH;
                BEQ:       state_reg <= FETCH;
                JAL:       state_reg <= ALU_WB;
                default:   state_reg <= ERROR;
            endcase
        end
    end

    // Outputs follow the state; only the fetch/branch strobes and the store
    // retirement look at mem_ready or zero_flag.
    always_comb begin
        mem_req           = 1'b0;
        mem_we            = 1'b0;
        adr_sel           = 1'b0;
        ir_write          = 1'b0;
        pc_write          = 1'b0;
        reg_write         = 1'b0;
        alu_src_a_sel     = 2'b00;
        alu_src_b_sel     = 2'b00;
        alu_operation_sel = ALU_ADD;
        imm_sel_out       = 2'b00;
        result_sel        = 2'b00;
        illegal_instr     = 1'b0;
        instr_retired     = 1'b0;
        case (state_reg)
            FETCH: begin
                mem_req       = 1'b1;
                alu_src_b_sel = 2'b10;
                result_sel    = 2'b10;
                ir_write      = mem_ready;
                pc_write      = mem_ready;
            end
            DECODE: begin
                alu_src_a_sel = 2'b01;
                alu_src_b_sel = 2'b01;
                imm_sel_out   = (opcode == OP_JAL) ? 2'b11 : 2'b10;
            end
            MEM_ADR: begin
                alu_src_a_sel = 2'b10;
                alu_src_b_sel = 2'b01;
                imm_sel_out   = (opcode == OP_LOAD) ? 2'b00 : 2'b01;
            end
            MEM_READ: begin
                mem_req = 1'b1;
                adr_sel = 1'b1;
            end
            MEM_WB: begin
                result_sel    = 2'b01;
                reg_write     = 1'b1;
                instr_retired = 1'b1;
            end
            MEM_WRITE: begin
                mem_req       = 1'b1;
                mem_we        = 1'b1;
                adr_sel       = 1'b1;
                instr_retired = mem_ready;
            end
            EXEC_R: begin
                alu_src_a_sel     = 2'b10;
                alu_operation_sel = dec_op;
            end
            EXEC_I: begin
                alu_src_a_sel     = 2'b10;
                alu_src_b_sel     = 2'b01;
                alu_operation_sel = dec_op;
            end
            ALU_WB: begin
                reg_write     = 1'b1;
                instr_retired = 1'b1;
            end
            BEQ: begin
                alu_src_a_sel     = 2'b10;
                alu_operation_sel = ALU_SUB;
                pc_write          = zero_flag;
                instr_retired     = 1'b1;
            end
            JAL: begin
                alu_src_a_sel = 2'b01;
                alu_src_b_sel = 2'b10;
                pc_write      = 1'b1;
            end
            default: begin
                illegal_instr = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks instruction sequences cycle by
// cycle and compares the full output bundle against hand-written vectors.
module tb_multicycle_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instruction;
    logic        zero_flag;
    logic        mem_ready;
    logic        mem_req, mem_we, adr_sel, ir_write, pc_write, reg_write;
    logic [1:0]  alu_src_a_sel, alu_src_b_sel, imm_sel_out, result_sel;
    logic [2:0]  alu_operation_sel;
    logic        illegal_instr, instr_retired;
    logic [18:0] obs_vec;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multicycle_controller dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .instruction       (instruction),
        .zero_flag         (zero_flag),
        .mem_ready         (mem_ready),
        .mem_req           (mem_req),
        .mem_we            (mem_we),
        .adr_sel           (adr_sel),
        .ir_write          (ir_write),
        .pc_write          (pc_write),
        .reg_write         (reg_write),
        .alu_src_a_sel     (alu_src_a_sel),
        .alu_src_b_sel     (alu_src_b_sel),
        .alu_operation_sel (alu_operation_sel),
        .imm_sel_out       (imm_sel_out),
        .result_sel        (result_sel),
        .illegal_instr     (illegal_instr),
        .instr_retired     (instr_retired)
    );

    assign obs_vec = {mem_req, mem_we, adr_sel, ir_write, pc_write, reg_write,
                      alu_src_a_sel, alu_src_b_sel, alu_operation_sel,
                      imm_sel_out, result_sel, illegal_instr, instr_retired};

    function automatic logic [18:0] ov(
        input logic mreq, input logic mwe, input logic adr,
        input logic irw, input logic pcw, input logic rw,
        input logic [1:0] a, input logic [1:0] b, input logic [2:0] alu,
        input logic [1:0] imm, input logic [1:0] res,
        input logic ill, input logic ret);
        return {mreq, mwe, adr, irw, pcw, rw, a, b, alu, imm, res, ill, ret};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Check outputs mid-cycle with the current inputs, then advance one clock.
    task automatic cyc(input string tag, input logic [18:0] exp);
        @(negedge clk);
        check(tag, {13'd0, obs_vec}, {13'd0, exp});
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    logic [18:0] e_fetch_wait, e_fetch_go, e_decode, e_err;

    initial begin
        e_fetch_wait = ov(1,0,0,0,0,0,2'b00,2'b10,3'b000,2'b00,2'b10,0,0);
        e_fetch_go   = ov(1,0,0,1,1,0,2'b00,2'b10,3'b000,2'b00,2'b10,0,0);
        e_decode     = ov(0,0,0,0,0,0,2'b01,2'b01,3'b000,2'b10,2'b00,0,0);
        e_err        = ov(0,0,0,0,0,0,2'b00,2'b00,3'b000,2'b00,2'b00,1,0);

        rst_n = 1'b0; instruction = 32'h0000_0013; zero_flag = 1'b0; mem_ready = 1'b0;
        @(posedge clk); #1;
        do_reset();
        cyc("reset_fetch", e_fetch_wait);
        cyc("reset_fetch_hold", e_fetch_wait);

        // addi x1,x0,5
        instruction = 32'h0050_0093; mem_ready = 1'b1;
        cyc("addi_fetch", e_fetch_go);
        mem_ready = 1'b0;
        cyc("addi_decode", e_decode);
        cyc("addi_exec_i", ov(0,0,0,0,0,0,2'b10,2'b01,3'b000,2'b00,2'b00,0,0));
        cyc("addi_alu_wb", ov(0,0,0,0,0,1,2'b00,2'b00,3'b000,2'b00,2'b00,0,1));
        $display("txn addi retired");

        // lw with three wait cycles; a stray mem_ready in MEM_ADR must be ignored
        instruction = 32'h0000_A083; mem_ready = 1'b1;
        cyc("lw_fetch", e_fetch_go);
        mem_ready = 1'b0;
        cyc("lw_decode", e_decode);
        mem_ready = 1'b1;
        cyc("lw_mem_adr", ov(0,0,0,0,0,0,2'b10,2'b01,3'b000,2'b00,2'b00,0,0));
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            cyc("lw_mem_read_wait", ov(1,0,1,0,0,0,2'b00,2'b00,3'b000,2'b00,2'b00,0,0));
        mem_ready = 1'b1;
        cyc("lw_mem_read_done", ov(1,0,1,0,0,0,2'b00,2'b00,3'b000,2'b00,2'b00,0,0));
        mem_ready = 1'b0;
        cyc("lw_mem_wb", ov(0,0,0,0,0,1,2'b00,2'b00,3'b000,2'b00,2'b01,0,1));
        cyc("lw_back_fetch", e_fetch_wait);
        $display("txn lw retired");

        // beq taken then not taken
        for (int z = 1; z >= 0; z--) begin
            instruction = 32'h0000_0063; mem_ready = 1'b1; zero_flag = z[0];
            cyc("beq_fetch", e_fetch_go);
            mem_ready = 1'b0;
            cyc("beq_decode", e_decode);
            cyc("beq_exec", ov(0,0,0,0,z[0],0,2'b10,2'b00,3'b001,2'b00,2'b00,0,1));
            cyc("beq_back_fetch", e_fetch_wait);
            $display("txn beq zero_flag=%0d retired", z);
        end
        zero_flag = 1'b0;

        // jal
        instruction = 32'h0000_006F; mem_ready = 1'b1;
        cyc("jal_fetch", e_fetch_go);
        mem_ready = 1'b0;
        cyc("jal_decode", ov(0,0,0,0,0,0,2'b01,2'b01,3'b000,2'b11,2'b00,0,0));
        cyc("jal_exec", ov(0,0,0,0,1,0,2'b01,2'b10,3'b000,2'b00,2'b00,0,0));
        cyc("jal_alu_wb", ov(0,0,0,0,0,1,2'b00,2'b00,3'b000,2'b00,2'b00,0,1));
        $display("txn jal retired");

        // R-type sub then and
        instruction = 32'h4020_8033; mem_ready = 1'b1;
        cyc("sub_fetch", e_fetch_go);
        mem_ready = 1'b0;
        cyc("sub_decode", e_decode);
        cyc("sub_exec_r", ov(0,0,0,0,0,0,2'b10,2'b00,3'b001,2'b00,2'b00,0,0));
        cyc("sub_alu_wb", ov(0,0,0,0,0,1,2'b00,2'b00,3'b000,2'b00,2'b00,0,1));
        instruction = 32'h0020_F0B3; mem_ready = 1'b1;
        cyc("and_fetch", e_fetch_go);
        mem_ready = 1'b0;
        cyc("and_decode", e_decode);
        cyc("and_exec_r", ov(0,0,0,0,0,0,2'b10,2'b00,3'b010,2'b00,2'b00,0,0));
        cyc("and_alu_wb", ov(0,0,0,0,0,1,2'b00,2'b00,3'b000,2'b00,2'b00,0,1));
        $display("txn r-type sub/and retired");

        // sw completing after one wait cycle
        instruction = 32'h0000_2023; mem_ready = 1'b1;
        cyc("sw_fetch", e_fetch_go);
        mem_ready = 1'b0;
        cyc("sw_decode", e_decode);
        cyc("sw_mem_adr", ov(0,0,0,0,0,0,2'b10,2'b01,3'b000,2'b01,2'b00,0,0));
        cyc("sw_mem_write_wait", ov(1,1,1,0,0,0,2'b00,2'b00,3'b000,2'b00,2'b00,0,0));
        mem_ready = 1'b1;
        cyc("sw_mem_write_done", ov(1,1,1,0,0,0,2'b00,2'b00,3'b000,2'b00,2'b00,0,1));
        mem_ready = 1'b0;
        cyc("sw_back_fetch", e_fetch_wait);
        $display("txn sw retired");

        // illegal opcode: sticky ERROR even with mem_ready, cleared by reset
        instruction = 32'h0000_007F; mem_ready = 1'b1;
        cyc("bad_op_fetch", e_fetch_go);
        mem_ready = 1'b0;
        cyc("bad_op_decode", e_decode);
        mem_ready = 1'b1;
        for (int i = 0; i < 3; i++)
            cyc("bad_op_error", e_err);
        do_reset();
        cyc("bad_op_reset_fetch", e_fetch_wait);
        $display("txn illegal opcode trapped and reset");

        // R-type funct7 = 0x01 is unsupported
        instruction = 32'h0220_8033; mem_ready = 1'b1;
        cyc("mul_fetch", e_fetch_go);
        mem_ready = 1'b0;
        cyc("mul_decode", e_decode);
        @(posedge clk); #1;
        cyc("mul_error", e_err);
        cyc("mul_error_sticky", e_err);
        $display("txn illegal funct7 trapped");

        // reset while a store is waiting on memory (also leaves ERROR)
        do_reset();
        instruction = 32'h0000_2023; mem_ready = 1'b1;
        cyc("swr_fetch", e_fetch_go);
        mem_ready = 1'b0;
        cyc("swr_decode", e_decode);
        cyc("swr_mem_adr", ov(0,0,0,0,0,0,2'b10,2'b01,3'b000,2'b01,2'b00,0,0));
        cyc("swr_mem_write_wait", ov(1,1,1,0,0,0,2'b00,2'b00,3'b000,2'b00,2'b00,0,0));
        rst_n = 1'b0;
        cyc("swr_reset_applied", ov(1,1,1,0,0,0,2'b00,2'b00,3'b000,2'b00,2'b00,0,0));
        rst_n = 1'b1;
        cyc("swr_after_reset", e_fetch_wait);
        $display("txn store aborted by reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
